alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute stage wrapped around the CPU's combinational ALU.
- Accepts one decoded ALU operation per handshake, latches the operands and drives the ALU.
- Captures the result and computes the Z/N/C/V flags, then holds a writeback beat for the register file.
- Commits flags to the architectural flags register only when the writeback is accepted.

Parameters:
- WORD_SIZE, 16, datapath width; must match the ALU's WORD_SIZE.
- REG_IDX_W, 3, width of destination register index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  stage can accept a request.
- in_op  in  opcode  ALU operation (shared opcode enum).
- in_a  in  WORD_SIZE  operand A.
- in_b  in  WORD_SIZE  operand B / shift amount.
- in_rd  in  REG_IDX_W  destination register index.
- in_upd_flags  in  1  commit flags for this operation.
- wb_valid  out  1  writeback beat valid.
- wb_ready  in  1  register file accepts beat.
- wb_rd  out  REG_IDX_W  destination index.
- wb_data  out  WORD_SIZE  ALU result.
- flag_z, flag_n, flag_c, flag_v  out  1 each  architectural flags.

Behaviour:
- Reset (async, rst_n low): state IDLE; wb_valid=0, wb_rd=0, wb_data=0; all flags=0; internal latches=0; in_ready=1 (IDLE).
- FSM: IDLE -> EXEC -> WB -> IDLE.
- IDLE: in_ready=1. On in_valid && in_ready at edge T, latch op/a/b/rd/upd and go to EXEC.
- EXEC (one cycle): in_ready=0. ALU is driven from the latches. At the edge, capture wb_data = ALU out, capture staged flags, and go to WB.
- WB: wb_valid=1 from T+2. wb_rd, wb_data and the staged flags are held stable while wb_ready=0. in_ready=0, and in_valid is ignored.
- WB handshake: on wb_valid && wb_ready, if upd then flags <= staged flags. Go to IDLE; wb_valid drops the next cycle.
- Minimum issue interval: 3 cycles. Without backpressure, the next request is accepted at T+3.
- Flag computation uses the latched a, b, op and r = ALU out.
  - Z = (r == 0).
  - N = r[MSB].
  - ADD: C = carry-out of the WORD_SIZE+1-bit sum; V = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
  - SUB: C = borrow = (a < b unsigned); V = (a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]).
  - LEFT_SHIFT: for 1<=b<=WORD_SIZE, C = a[WORD_SIZE-b]; otherwise C=0. V=0.
  - RIGHT_SHIFT_ARITHMETIC and RIGHT_SHIFT_LOGIC: for 1<=b<=WORD_SIZE, C = a[b-1]; otherwise C=0. V=0.
  - AND, OR, XOR, EQUAL, and any unlisted op: C=0, V=0.
- wb_data is exactly the ALU output. This stage does not correct shift results.
- Shift amount is the full unsigned b. b==0 means no shift and C=0. b>WORD_SIZE means C=0.
- Reset mid-operation (EXEC or WB): the operation is aborted, no flag commit occurs, and all outputs return to reset values asynchronously.
- in_upd_flags=0: flags are never modified; the writeback still occurs.

Decomposition:
- Shared package orgasmall_pkg holds:
  - the opcode enum (moved out of the ALU file; the ALU imports it);
  - the exec-state enum (IDLE, EXEC, WB);
  - the flags struct {z, n, c, v}.
- One sub-module: alu_flags, purely combinational. Inputs: op, a, b, r. Output: the flags struct.
- The existing alu is instantiated unchanged.

Test Plan:
- ADD a=0xFFFF, b=0x0001, upd=1, wb_ready=1 -> wb_valid at T+2 with wb_data=0x0000. After the handshake: Z=1, C=1, N=0, V=0.
- SUB a=0x8000, b=0x0001, upd=1 -> wb_data=0x7FFF; Z=0, N=0, C=0, V=1. Then SUB 0x0001-0x0002 -> 0xFFFF; N=1, C=1, V=0.
- LEFT_SHIFT a=0x8001:
  - b=1 -> 0x0002, C=1.
  - b=0 -> 0x8001, C=0, N=1.
  - b=20 -> 0x0000, Z=1, C=0.
- Backpressure: hold wb_ready=0 for 5 cycles during WB while in_valid=1 with new data.
  - wb_data, wb_rd and the flags stay unchanged; in_ready=0; the new request is not accepted.
  - wb_ready=1 -> flags commit; the request is accepted in IDLE the next cycle.
- EQUAL a=5, b=5, upd=0 after flags Z=1, C=1 -> wb_data=0x0001, rd echoed; flags remain Z=1, C=1.
- Drop rst_n during EXEC of ADD 0x7FFF+1 -> wb_valid, wb_data and all flags go to 0 immediately, with no writeback beat. After release, in_ready=1.

Source files
------------

// File: rtl/orgasmall_pkg.sv
// rtl/orgasmall_pkg.sv - shared opcode, exec-state and flag types for the ALU execute stage
package orgasmall_pkg;

    typedef enum logic [3:0] {
        ADD,
        SUB,
        AND,
        OR,
        XOR,
        LEFT_SHIFT,
        RIGHT_SHIFT_ARITHMETIC,
        RIGHT_SHIFT_LOGIC,
        EQUAL
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } exec_state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU; shift amount is the full unsigned operand b
module alu
    import orgasmall_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  opcode_t              op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic [WORD_SIZE-1:0] out
);

    always_comb begin
        out = '0;
        case (op)
            ADD:                    out = a + b;
            SUB:                    out = a - b;
            AND:                    out = a & b;
            OR:                     out = a | b;
            XOR:                    out = a ^ b;
            LEFT_SHIFT:             out = a << b;
            RIGHT_SHIFT_ARITHMETIC: out = $signed(a) >>> b;
            RIGHT_SHIFT_LOGIC:      out = a >> b;
            EQUAL:                  out = {{(WORD_SIZE-1){1'b0}}, (a == b)};
            default:                out = '0;
        endcase
    end

endmodule

// File: rtl/alu_flags.sv
// rtl/alu_flags.sv - Z/N/C/V derivation from the latched operands and the ALU result
module alu_flags
    import orgasmall_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  opcode_t              op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic [WORD_SIZE-1:0] r,
    output flags_t               flags
);

    localparam int MSB = WORD_SIZE - 1;

    always_comb begin
        flags   = '0;
        flags.z = (r == '0);
        flags.n = r[MSB];
        case (op)
            ADD: begin
                flags.c = |(({1'b0, a} + {1'b0, b}) >> WORD_SIZE);
                flags.v = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
            end
            SUB: begin
                flags.c = (a < b);
                flags.v = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
            end
            // Last bit shifted out; zero for b==0 and for b beyond the word
            LEFT_SHIFT: begin
                flags.c = |(({1'b0, a} << b) >> WORD_SIZE);
            end
            RIGHT_SHIFT_ARITHMETIC, RIGHT_SHIFT_LOGIC: begin
                flags.c = |(({a, 1'b0} >> b) & {{WORD_SIZE{1'b0}}, 1'b1});
            end
            default: begin
                flags.c = 1'b0;
                flags.v = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute stage: latch operands, run ALU, hold writeback, commit flags on accept
module alu_exec_stage
    import orgasmall_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int REG_IDX_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  opcode_t              in_op,
    input  logic [WORD_SIZE-1:0] in_a,
    input  logic [WORD_SIZE-1:0] in_b,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_upd_flags,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [WORD_SIZE-1:0] wb_data,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 flag_c,
    output logic                 flag_v
);

    exec_state_t          state, next_state;
    opcode_t              op_q;
    logic [WORD_SIZE-1:0] a_q, b_q, alu_out;
    logic [REG_IDX_W-1:0] rd_q;
    logic                 upd_q;
    flags_t               flags_calc, staged_q, flags_q;

    alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .out (alu_out)
    );

    alu_flags #(.WORD_SIZE(WORD_SIZE)) u_flags (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .r     (alu_out),
        .flags (flags_calc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        wb_valid   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = EXEC;
            end
            EXEC: next_state = WB;
            WB: begin
                wb_valid = 1'b1;
                if (wb_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= ADD;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            upd_q    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            staged_q <= '0;
            flags_q  <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                op_q  <= in_op;
                a_q   <= in_a;
                b_q   <= in_b;
                rd_q  <= in_rd;
                upd_q <= in_upd_flags;
            end
            if (state == EXEC) begin
                wb_data  <= alu_out;
                wb_rd    <= rd_q;
                staged_q <= flags_calc;
            end
            // Architectural flags change only when the register file takes the beat
            if (state == WB && wb_ready && upd_q) flags_q <= staged_q;
        end
    end

    assign flag_z = flags_q.z;
    assign flag_n = flags_q.n;
    assign flag_c = flags_q.c;
    assign flag_v = flags_q.v;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed self-checking bench for alu_exec_stage
module tb_alu_exec_stage;
    import orgasmall_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    opcode_t     in_op;
    logic [15:0] in_a, in_b;
    logic [2:0]  in_rd;
    logic        in_upd_flags;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        flag_z, flag_n, flag_c, flag_v;
    logic [3:0]  fl;

    int compared   = 0;
    int mismatched = 0;

    assign fl = {flag_z, flag_n, flag_c, flag_v};

    always #5 clk = ~clk;

    alu_exec_stage #(.WORD_SIZE(16), .REG_IDX_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_rd        (in_rd),
        .in_upd_flags (in_upd_flags),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .flag_c       (flag_c),
        .flag_v       (flag_v)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input opcode_t op, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] rd, input logic upd);
        in_valid     = 1'b1;
        in_op        = op;
        in_a         = a;
        in_b         = b;
        in_rd        = rd;
        in_upd_flags = upd;
    endtask

    // Full transaction with wb_ready held high; called #1 after a rising edge
    task automatic run_op(input string tag, input opcode_t op, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] rd, input logic upd,
                          input logic [15:0] exp_data, input logic [3:0] exp_flags);
        chk({tag, ".in_ready_idle"}, in_ready, 1);
        drive(op, a, b, rd, upd);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, ".wb_valid_exec"}, wb_valid, 0);
        chk({tag, ".in_ready_exec"}, in_ready, 0);
        @(posedge clk); #1;
        chk({tag, ".wb_valid"}, wb_valid, 1);
        chk({tag, ".wb_data"}, wb_data, exp_data);
        chk({tag, ".wb_rd"}, wb_rd, rd);
        @(posedge clk); #1;
        chk({tag, ".flags"}, fl, exp_flags);
        chk({tag, ".wb_valid_after"}, wb_valid, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_op        = ADD;
        in_a         = '0;
        in_b         = '0;
        in_rd        = '0;
        in_upd_flags = 1'b0;
        wb_ready     = 1'b1;
        #12;
        chk("reset.wb_valid", wb_valid, 0);
        chk("reset.wb_data", wb_data, 0);
        chk("reset.wb_rd", wb_rd, 0);
        chk("reset.flags", fl, 0);
        chk("reset.in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // flags vector is {z, n, c, v}
        run_op("add_wrap", ADD, 16'hFFFF, 16'h0001, 3'd1, 1'b1, 16'h0000, 4'b1010);
        run_op("sub_ovf",  SUB, 16'h8000, 16'h0001, 3'd2, 1'b1, 16'h7FFF, 4'b0001);
        run_op("sub_brw",  SUB, 16'h0001, 16'h0002, 3'd3, 1'b1, 16'hFFFF, 4'b0110);
        run_op("lsl_b1",   LEFT_SHIFT, 16'h8001, 16'd1,  3'd4, 1'b1, 16'h0002, 4'b0010);
        run_op("lsl_b0",   LEFT_SHIFT, 16'h8001, 16'd0,  3'd4, 1'b1, 16'h8001, 4'b0100);
        run_op("lsl_b20",  LEFT_SHIFT, 16'h8001, 16'd20, 3'd4, 1'b1, 16'h0000, 4'b1000);
        run_op("lsr_b1",   RIGHT_SHIFT_LOGIC, 16'h0003, 16'd1, 3'd5, 1'b1, 16'h0001, 4'b0010);
        run_op("asr_b15",  RIGHT_SHIFT_ARITHMETIC, 16'h8000, 16'd15, 3'd5, 1'b1, 16'hFFFF, 4'b0100);

        // Backpressure in WB with a competing request on the input side
        wb_ready = 1'b0;
        chk("bp.in_ready_idle", in_ready, 1);
        drive(ADD, 16'hFFFF, 16'h0001, 3'd5, 1'b1);
        @(posedge clk); #1;
        drive(EQUAL, 16'd5, 16'd5, 3'd6, 1'b0);
        chk("bp.in_ready_exec", in_ready, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp.wb_valid_%0d", i), wb_valid, 1);
            chk($sformatf("bp.wb_data_%0d", i), wb_data, 16'h0000);
            chk($sformatf("bp.wb_rd_%0d", i), wb_rd, 3'd5);
            chk($sformatf("bp.flags_held_%0d", i), fl, 4'b0100);
            chk($sformatf("bp.in_ready_%0d", i), in_ready, 0);
            @(posedge clk); #1;
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.flags_commit", fl, 4'b1010);
        chk("bp.wb_valid_drop", wb_valid, 0);
        chk("bp.in_ready_after", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("eq.in_ready_exec", in_ready, 0);
        @(posedge clk); #1;
        chk("eq.wb_valid", wb_valid, 1);
        chk("eq.wb_data", wb_data, 16'h0001);
        chk("eq.wb_rd", wb_rd, 3'd6);
        @(posedge clk); #1;
        chk("eq.flags_kept", fl, 4'b1010);
        chk("eq.wb_valid_after", wb_valid, 0);

        // Asynchronous reset while the operation sits in EXEC
        drive(ADD, 16'h7FFF, 16'h0001, 3'd7, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst.wb_valid_exec", wb_valid, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst.wb_valid", wb_valid, 0);
        chk("rst.wb_data", wb_data, 0);
        chk("rst.flags", fl, 0);
        chk("rst.wb_rd", wb_rd, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.no_beat_0", wb_valid, 0);
        chk("rst.in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("rst.no_beat_1", wb_valid, 0);
        chk("rst.flags_still0", fl, 0);

        run_op("add_ovf", ADD, 16'h7FFF, 16'h0001, 3'd7, 1'b1, 16'h8000, 4'b0101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
